// File: rtl/sw_input_conditioner.sv
// Slide-switch conditioner: two-flop synchronizer, optional per-bit debounce
// (enabled by the SW_DEBOUNCE_EN macro), stable output word and sticky change record.
module sw_input_conditioner #(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             ack,
    output logic [WIDTH-1:0] sw_out,
    output logic             changed,
    output logic [WIDTH-1:0] change_mask
);

    // The counter must be able to reach DEBOUNCE_CYCLES-1 without wrapping.
    if (DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) < DEBOUNCE_CYCLES) begin : g_bad_param
        $error("sw_input_conditioner: illegal DEBOUNCE_CYCLES/CNT_W");
    end

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] sw_q, sw_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] upd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef SW_DEBOUNCE_EN
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             differ, expire;

        assign differ      = sync2_q[gi] ^ sw_q[gi];
        assign expire      = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
        assign sw_d[gi]    = (differ && expire) ? sync2_q[gi] : sw_q[gi];
        // Any return to the stable level, or an acceptance, restarts the count.
        assign cnt_d       = (differ && !expire) ? cnt_q + CNT_W'(1) : '0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end
`else
    assign sw_d = sync2_q;
`endif

    assign upd = sw_d ^ sw_q;

    // A fresh update on the ack edge survives the clear.
    always_comb begin
        mask_d    = ack ? upd : (mask_q | upd);
        changed_d = |mask_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q      <= '0;
            mask_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sw_q      <= sw_d;
            mask_q    <= mask_d;
            changed_q <= changed_d;
        end
    end

    assign sw_out      = sw_q;
    assign change_mask = mask_q;
    assign changed     = changed_q;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner; expectations follow the SW_DEBOUNCE_EN setting.
module tb_sw_input_conditioner;

    localparam int WIDTH = 18;
    localparam int DC    = 4;
`ifdef SW_DEBOUNCE_EN
    localparam int LAT = 2 + DC;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sw_in;
    logic             ack;
    logic [WIDTH-1:0] sw_out;
    logic             changed;
    logic [WIDTH-1:0] change_mask;

    int n_cmp = 0;
    int n_err = 0;

    sw_input_conditioner #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_in      (sw_in),
        .ack        (ack),
        .sw_out     (sw_out),
        .changed    (changed),
        .change_mask(change_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        sw_in = 18'h3FFFF;
        ack   = 1'b0;
        step(2);
        chk("rst_sw_out", 32'(sw_out), 32'h0);
        chk("rst_changed", 32'(changed), 32'h0);
        chk("rst_mask", 32'(change_mask), 32'h0);

        rst = 1'b0;
        step(LAT - 1);
        chk("rel_early", 32'(sw_out), 32'h0);
        step(1);
        chk("rel_sw_out", 32'(sw_out), 32'h3FFFF);
        chk("rel_mask", 32'(change_mask), 32'h3FFFF);
        chk("rel_changed", 32'(changed), 32'h1);

        pulse_ack();
        chk("ack_changed", 32'(changed), 32'h0);
        chk("ack_mask", 32'(change_mask), 32'h0);

        sw_in = '0;
        step(LAT);
        chk("fall_sw_out", 32'(sw_out), 32'h0);
        chk("fall_mask", 32'(change_mask), 32'h3FFFF);
        pulse_ack();

        // Three-clock pulse on bit 0.
        sw_in = 18'h00001;
        step(3);
        sw_in = '0;
`ifdef SW_DEBOUNCE_EN
        for (int i = 0; i < 20; i++) begin
            chk("glitch_sw_out", 32'(sw_out), 32'h0);
            chk("glitch_changed", 32'(changed), 32'h0);
            step(1);
        end
`else
        chk("pulse_hi0", 32'(sw_out), 32'h1);
        step(2);
        chk("pulse_hi2", 32'(sw_out), 32'h1);
        step(1);
        chk("pulse_lo", 32'(sw_out), 32'h0);
        chk("pulse_mask", 32'(change_mask), 32'h1);
        pulse_ack();
`endif

        sw_in = 18'h00005;
        step(LAT - 1);
        chk("clean_early", 32'(sw_out), 32'h0);
        step(1);
        chk("clean_sw_out", 32'(sw_out), 32'h5);
        chk("clean_changed", 32'(changed), 32'h1);
        chk("clean_mask", 32'(change_mask), 32'h5);

        pulse_ack();
        chk("ack2_mask", 32'(change_mask), 32'h0);
        pulse_ack();
        chk("noop_changed", 32'(changed), 32'h0);
        chk("noop_sw_out", 32'(sw_out), 32'h5);

        // Bit 1 acceptance lands on the same edge as ack.
        sw_in = 18'h00007;
        step(LAT - 1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("coinc_changed", 32'(changed), 32'h1);
        chk("coinc_mask", 32'(change_mask), 32'h2);
        chk("coinc_sw_out", 32'(sw_out), 32'h7);
        pulse_ack();

        // Asynchronous reset shortly after edge 4 of a pending change.
        sw_in = 18'h00017;
        step(3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sw_out", 32'(sw_out), 32'h0);
        chk("arst_changed", 32'(changed), 32'h0);
        chk("arst_mask", 32'(change_mask), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(LAT - 1);
        chk("arst_early", 32'(sw_out), 32'h0);
        step(1);
        chk("arst_sw_out2", 32'(sw_out), 32'h17);
        chk("arst_mask2", 32'(change_mask), 32'h17);

        sw_in = '0;
        step(LAT);
        pulse_ack();
        chk("clr_mask", 32'(change_mask), 32'h0);

        sw_in = 18'h2A5A5;
        step(LAT - 1);
        chk("wide_early", 32'(sw_out), 32'h0);
        step(1);
        chk("wide_sw_out", 32'(sw_out), 32'h2A5A5);
        chk("wide_mask", 32'(change_mask), 32'h2A5A5);

`ifndef SW_DEBOUNCE_EN
        // One-clock glitch on bit 3 passes straight through.
        sw_in = 18'h2A5AD;
        step(1);
        sw_in = 18'h2A5A5;
        step(1);
        chk("g3_before", 32'(sw_out), 32'h2A5A5);
        step(1);
        chk("g3_during", 32'(sw_out), 32'h2A5AD);
        step(1);
        chk("g3_after", 32'(sw_out), 32'h2A5A5);
        chk("g3_mask", 32'(change_mask), 32'h2A5AD);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
